psram_qpi_dev: RTL and testbench

Parametrised, synthesizable PSRAM device model for the SoC PSRAM controller path. It is the next generation of the quad-SPI PSRAM slave.
- Oversamples sck/ce_n in the system clock domain; no DPI.
- Holds a local byte array.
- Adds QPI mode entry/exit, configurable read latency, unbounded byte bursts with address wrap, and an error flag.
- Instantiated in the simulation top in place of the DPI-backed model; the controller-facing pins are unchanged except that the tri-state is split.

---
 rtl/psram_pkg.sv | 29 ++
 rtl/psram_qpi_dev_mem.sv | 24 ++
 rtl/psram_qpi_dev.sv | 219 +++++++++++++++++++++
 tb/tb_psram_qpi_dev.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and protocol constants for the QPI PSRAM device model.
// Imported by the top-level FSM and the byte-array sub-module.
package psram_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_RDATA,
        S_WDATA,
        S_ERR,
        S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;

    localparam int CMD_NIB_SPI = 8;
    localparam int CMD_NIB_QPI = 2;
    localparam int ADDR_NIB    = 6;

    // Commands that carry an address phase and move data.
    function automatic logic is_rw_cmd(input logic [7:0] cmd);
        return (cmd == CMD_QREAD) || (cmd == CMD_QWRITE);
    endfunction

endpackage

// File: rtl/psram_qpi_dev_mem.sv
// Byte array backing the PSRAM model: one asynchronous read port and one
// synchronous write port. Contents are intentionally not reset.
module psram_qpi_dev_mem #(
    parameter int MEM_LOG2 = 16
) (
    input  logic                clock,
    input  logic                we,
    input  logic [MEM_LOG2-1:0] waddr,
    input  logic [7:0]          wdata,
    input  logic [MEM_LOG2-1:0] raddr,
    output logic [7:0]          rdata
);

    logic [7:0] mem [0:(2**MEM_LOG2)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psram_qpi_dev.sv
// Synthesizable quad-SPI / QPI PSRAM device model. sck and ce_n are
// oversampled in the system clock domain; protocol actions follow detected edges.
module psram_qpi_dev
    import psram_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int MEM_LOG2  = 16,
    parameter int READ_WAIT = 6,
    parameter int QPI_EN    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_o,
    output logic [3:0] dio_oe,
    output logic       qpi_mode,
    output logic       err
);

    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    state_t                state_reg, state_next;
    logic                  sck_q;
    logic [3:0]            cnt_reg, cnt_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [7:0]            cmd_reg, cmd_next;
    logic [ADDR_W-1:0]     addr_sh_reg, addr_sh_next;
    logic [MEM_LOG2-1:0]   addr_reg, addr_next;
    logic                  nib_sel_reg, nib_sel_next;
    logic [3:0]            wr_hi_reg, wr_hi_next;
    logic [3:0]            dio_o_reg, dio_o_next;
    logic [3:0]            dio_oe_reg, dio_oe_next;
    logic                  qpi_reg, qpi_next;
    logic                  err_reg, err_next;

    logic                  rise;
    logic                  fall;
    logic [7:0]            cmd_shift;
    logic [ADDR_W-1:0]     addr_shift;
    logic                  cmd_last;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    assign rise = sck & ~sck_q;
    assign fall = ~sck & sck_q;

    psram_qpi_dev_mem #(
        .MEM_LOG2 (MEM_LOG2)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (addr_reg),
        .wdata (mem_wdata),
        .raddr (addr_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_CMD;
            sck_q        <= 1'b0;
            cnt_reg      <= '0;
            wait_cnt_reg <= '0;
            cmd_reg      <= '0;
            addr_sh_reg  <= '0;
            addr_reg     <= '0;
            nib_sel_reg  <= 1'b0;
            wr_hi_reg    <= '0;
            dio_o_reg    <= '0;
            dio_oe_reg   <= '0;
            qpi_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sck_q        <= sck;
            cnt_reg      <= cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            cmd_reg      <= cmd_next;
            addr_sh_reg  <= addr_sh_next;
            addr_reg     <= addr_next;
            nib_sel_reg  <= nib_sel_next;
            wr_hi_reg    <= wr_hi_next;
            dio_o_reg    <= dio_o_next;
            dio_oe_reg   <= dio_oe_next;
            qpi_reg      <= qpi_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        cmd_next      = cmd_reg;
        addr_sh_next  = addr_sh_reg;
        addr_next     = addr_reg;
        nib_sel_next  = nib_sel_reg;
        wr_hi_next    = wr_hi_reg;
        dio_o_next    = dio_o_reg;
        dio_oe_next   = dio_oe_reg;
        qpi_next      = qpi_reg;
        err_next      = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = {wr_hi_reg, dio_i};

        cmd_shift  = qpi_reg ? {cmd_reg[3:0], dio_i} : {cmd_reg[6:0], dio_i[0]};
        addr_shift = {addr_sh_reg[ADDR_W-5:0], dio_i};
        cmd_last   = qpi_reg ? (cnt_reg == 4'(CMD_NIB_QPI - 1))
                             : (cnt_reg == 4'(CMD_NIB_SPI - 1));

        // Deselect overrides any sck edge seen in the same cycle.
        if (ce_n) begin
            state_next    = S_CMD;
            cnt_next      = '0;
            wait_cnt_next = '0;
            cmd_next      = '0;
            addr_sh_next  = '0;
            addr_next     = '0;
            nib_sel_next  = 1'b0;
            wr_hi_next    = '0;
            dio_oe_next   = '0;
        end else begin
            case (state_reg)
                S_CMD: begin
                    if (rise) begin
                        cmd_next = cmd_shift;
                        cnt_next = cnt_reg + 4'd1;
                        if (cmd_last) begin
                            cnt_next = '0;
                            if (is_rw_cmd(cmd_shift)) begin
                                state_next = S_ADDR;
                            end else if ((QPI_EN != 0) && !qpi_reg && (cmd_shift == CMD_QPI_EN)) begin
                                qpi_next   = 1'b1;
                                state_next = S_IGNORE;
                            end else if ((QPI_EN != 0) && qpi_reg && (cmd_shift == CMD_QPI_EX)) begin
                                qpi_next   = 1'b0;
                                state_next = S_IGNORE;
                            end else begin
                                err_next   = 1'b1;
                                state_next = S_ERR;
                            end
                        end
                    end
                end

                S_ADDR: begin
                    if (rise) begin
                        addr_sh_next = addr_shift;
                        cnt_next     = cnt_reg + 4'd1;
                        if (cnt_reg == 4'(ADDR_NIB - 1)) begin
                            cnt_next  = '0;
                            addr_next = addr_shift[MEM_LOG2-1:0];
                            if (cmd_reg == CMD_QWRITE) begin
                                state_next = S_WDATA;
                            end else if (READ_WAIT == 0) begin
                                state_next  = S_RDATA;
                                dio_oe_next = 4'hF;
                            end else begin
                                state_next = S_WAIT;
                            end
                        end
                    end
                end

                S_WAIT: begin
                    if (rise) begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                        if (wait_cnt_reg == WAIT_W'(READ_WAIT - 1)) begin
                            wait_cnt_next = '0;
                            state_next    = S_RDATA;
                            dio_oe_next   = 4'hF;
                        end
                    end
                end

                S_RDATA: begin
                    dio_oe_next = 4'hF;
                    // High nibble first; the address advances after the low nibble.
                    if (fall) begin
                        if (!nib_sel_reg) begin
                            dio_o_next   = mem_rdata[7:4];
                            nib_sel_next = 1'b1;
                        end else begin
                            dio_o_next   = mem_rdata[3:0];
                            nib_sel_next = 1'b0;
                            addr_next    = addr_reg + MEM_LOG2'(1);
                        end
                    end
                end

                S_WDATA: begin
                    if (rise) begin
                        if (!nib_sel_reg) begin
                            wr_hi_next   = dio_i;
                            nib_sel_next = 1'b1;
                        end else begin
                            mem_we       = 1'b1;
                            nib_sel_next = 1'b0;
                            addr_next    = addr_reg + MEM_LOG2'(1);
                        end
                    end
                end

                default: begin
                    dio_oe_next = '0;
                end
            endcase
        end
    end

    assign dio_o    = dio_o_reg;
    assign dio_oe   = dio_oe_reg;
    assign qpi_mode = qpi_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_psram_qpi_dev.sv
// Directed self-checking bench for psram_qpi_dev: SPI/QPI reads and writes,
// address wrap, illegal commands, partial bytes and mid-transfer reset.
module tb_psram_qpi_dev;

    localparam int RW = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       sck;
    logic       ce_n;
    logic [3:0] dio_i;
    logic [3:0] dio_o;
    logic [3:0] dio_oe;
    logic       qpi_mode;
    logic       err;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_cycles   = 0;
    int oe_hits      = 0;

    psram_qpi_dev #(
        .ADDR_W    (24),
        .MEM_LOG2  (16),
        .READ_WAIT (RW),
        .QPI_EN    (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sck      (sck),
        .ce_n     (ce_n),
        .dio_i    (dio_i),
        .dio_o    (dio_o),
        .dio_oe   (dio_oe),
        .qpi_mode (qpi_mode),
        .err      (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (err === 1'b1) err_cycles++;
        if (dio_oe !== 4'h0) oe_hits++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse();
        sck = 1'b1;
        tick(3);
        sck = 1'b0;
        tick(3);
    endtask

    task automatic cs_begin();
        ce_n = 1'b0;
        tick(3);
    endtask

    task automatic cs_end();
        ce_n = 1'b1;
        tick(3);
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit qpi);
        if (qpi) begin
            for (int i = 0; i < 2; i++) begin
                dio_i = c[4*(1-i) +: 4];
                pulse();
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                dio_i = {3'b000, c[7-i]};
                pulse();
            end
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 0; i < 6; i++) begin
            dio_i = a[4*(5-i) +: 4];
            pulse();
        end
    endtask

    task automatic write_nibs(input logic [23:0] a, input bit qpi, input int nnib, input logic [31:0] nibs);
        cs_begin();
        send_cmd(8'h38, qpi);
        send_addr(a);
        for (int i = 0; i < nnib; i++) begin
            dio_i = nibs[4*(nnib-1-i) +: 4];
            pulse();
        end
        cs_end();
    endtask

    task automatic read_bytes(input logic [23:0] a, input bit qpi, input int nbytes,
                              output logic [31:0] data, output int oe_bad);
        data   = '0;
        oe_bad = 0;
        cs_begin();
        send_cmd(8'hEB, qpi);
        send_addr(a);
        for (int w = 0; w < RW; w++) begin
            if (dio_oe !== 4'h0) oe_bad++;
            dio_i = 4'h0;
            pulse();
        end
        for (int i = 0; i < 2*nbytes; i++) begin
            if (i > 0) pulse();
            if (dio_oe !== 4'hF) oe_bad++;
            data = {data[27:0], dio_o};
        end
        cs_end();
    endtask

    task automatic test_reset();
        reset = 1'b1; ce_n = 1'b1; sck = 1'b0; dio_i = 4'h0;
        tick(4);
        tests_run++;
        if (dio_o !== 4'h0) begin tests_failed++; $display("FAIL reset_dio_o got %h want 0", dio_o); end
        tests_run++;
        if (dio_oe !== 4'h0) begin tests_failed++; $display("FAIL reset_dio_oe got %h want 0", dio_oe); end
        tests_run++;
        if (qpi_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_qpi got %b want 0", qpi_mode); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
        reset = 1'b0;
        tick(2);
        $display("[TB] reset checked");
    endtask

    task automatic test_spi_write();
        oe_hits = 0;
        write_nibs(24'h000010, 1'b0, 4, 32'h0000A53C);
        tests_run++;
        if (oe_hits !== 0) begin tests_failed++; $display("FAIL spi_write_oe got %0d driven cycles want 0", oe_hits); end
        $display("[TB] spi write 0x000010 <= A5 3C");
    endtask

    task automatic test_spi_read();
        logic [31:0] d;
        int bad;
        read_bytes(24'h000010, 1'b0, 2, d, bad);
        tests_run++;
        if (d[15:0] !== 16'hA53C) begin tests_failed++; $display("FAIL spi_read_data got %h want A53C", d[15:0]); end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL spi_read_oe got %0d bad samples want 0", bad); end
        tests_run++;
        if (dio_oe !== 4'h0) begin tests_failed++; $display("FAIL spi_read_oe_idle got %h want 0", dio_oe); end
        $display("[TB] spi read 0x000010 -> %h", d[15:0]);
    endtask

    task automatic test_qpi();
        logic [31:0] d;
        int bad;
        cs_begin(); send_cmd(8'h35, 1'b0); cs_end();
        tests_run++;
        if (qpi_mode !== 1'b1) begin tests_failed++; $display("FAIL qpi_enter got %b want 1", qpi_mode); end
        read_bytes(24'h000010, 1'b1, 2, d, bad);
        tests_run++;
        if (d[15:0] !== 16'hA53C) begin tests_failed++; $display("FAIL qpi_read_data got %h want A53C", d[15:0]); end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL qpi_read_oe got %0d bad samples want 0", bad); end
        cs_begin(); send_cmd(8'hF5, 1'b1); cs_end();
        tests_run++;
        if (qpi_mode !== 1'b0) begin tests_failed++; $display("FAIL qpi_exit got %b want 0", qpi_mode); end
        read_bytes(24'h000011, 1'b0, 1, d, bad);
        tests_run++;
        if (d[7:0] !== 8'h3C) begin tests_failed++; $display("FAIL post_qpi_spi_read got %h want 3C", d[7:0]); end
        $display("[TB] qpi enter/read/exit done, spi read 0x000011 -> %h", d[7:0]);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int bad;
        write_nibs(24'h00FFFF, 1'b0, 6, 32'h00112233);
        read_bytes(24'h00FFFF, 1'b0, 3, d, bad);
        tests_run++;
        if (d[23:0] !== 24'h112233) begin tests_failed++; $display("FAIL wrap_read got %h want 112233", d[23:0]); end
        read_bytes(24'h120000, 1'b0, 1, d, bad);
        tests_run++;
        if (d[7:0] !== 8'h22) begin tests_failed++; $display("FAIL high_addr_ignored got %h want 22", d[7:0]); end
        read_bytes(24'h000001, 1'b0, 1, d, bad);
        tests_run++;
        if (d[7:0] !== 8'h33) begin tests_failed++; $display("FAIL wrap_addr1 got %h want 33", d[7:0]); end
        $display("[TB] wrap burst at 0xFFFF checked");
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        int bad;
        err_cycles = 0;
        cs_begin();
        send_cmd(8'h9F, 1'b0);
        tick(2);
        tests_run++;
        if (err_cycles !== 1) begin tests_failed++; $display("FAIL err_pulse got %0d cycles want 1", err_cycles); end
        tests_run++;
        if (dio_oe !== 4'h0) begin tests_failed++; $display("FAIL err_oe got %h want 0", dio_oe); end
        send_cmd(8'h00, 1'b0);
        send_cmd(8'hEB, 1'b0);
        send_addr(24'h000010);
        tests_run++;
        if (err_cycles !== 1) begin tests_failed++; $display("FAIL err_ignore got %0d cycles want 1", err_cycles); end
        tests_run++;
        if (dio_oe !== 4'h0) begin tests_failed++; $display("FAIL err_ignore_oe got %h want 0", dio_oe); end
        cs_end();
        read_bytes(24'h000010, 1'b0, 1, d, bad);
        tests_run++;
        if (d[7:0] !== 8'hA5) begin tests_failed++; $display("FAIL post_err_read got %h want A5", d[7:0]); end
        $display("[TB] illegal 9F -> err cycles %0d, recovery read %h", err_cycles, d[7:0]);
    endtask

    task automatic test_partial();
        logic [31:0] d;
        int bad;
        write_nibs(24'h000020, 1'b0, 4, 32'h000000EE);
        write_nibs(24'h000020, 1'b0, 3, 32'h00000778);
        read_bytes(24'h000020, 1'b0, 2, d, bad);
        tests_run++;
        if (d[15:0] !== 16'h77EE) begin tests_failed++; $display("FAIL partial_byte got %h want 77EE", d[15:0]); end
        $display("[TB] partial write at 0x20 -> %h", d[15:0]);
    endtask

    task automatic test_reset_mid();
        cs_begin(); send_cmd(8'h35, 1'b0); cs_end();
        cs_begin();
        send_cmd(8'hEB, 1'b1);
        send_addr(24'h000010);
        dio_i = 4'h0;
        for (int w = 0; w < RW; w++) pulse();
        tests_run++;
        if (dio_oe !== 4'hF) begin tests_failed++; $display("FAIL mid_rdata_oe got %h want F", dio_oe); end
        tests_run++;
        if (dio_o !== 4'hA) begin tests_failed++; $display("FAIL mid_rdata_nib got %h want A", dio_o); end
        reset = 1'b1;
        tick(1);
        tests_run++;
        if (dio_oe !== 4'h0) begin tests_failed++; $display("FAIL reset_mid_oe got %h want 0", dio_oe); end
        tests_run++;
        if (qpi_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_qpi got %b want 0", qpi_mode); end
        reset = 1'b0;
        ce_n  = 1'b1;
        tick(3);
        $display("[TB] reset during QPI read checked");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int bad;
        read_bytes(24'h000011, 1'b0, 1, d, bad);
        tests_run++;
        if (d[7:0] !== 8'h3C) begin tests_failed++; $display("FAIL post_reset_read got %h want 3C", d[7:0]); end
        $display("[TB] post-reset spi read 0x000011 -> %h", d[7:0]);
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_spi_read();
        test_qpi();
        test_wrap();
        test_illegal();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
